// File: rtl/sd_emmc_ddr_pkg.sv
// Shared constants and state encoding for the eMMC DDR write-data sequencer.
package sd_emmc_ddr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_CRC   = 3'd4,
    ST_END   = 3'd5,
    ST_GAP   = 3'd6
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [7:0]  START_BYTE = 8'h00;
  localparam logic [7:0]  IDLE_BYTE  = 8'hFF;
  localparam int          CRC_LEN    = 16;

endpackage

// File: rtl/sd_emmc_crc16_ser.sv
// Bit-serial CRC16-CCITT for one DAT line stream; after the data phase the
// remainder is shifted out MSB first on dout.
module sd_emmc_crc16_ser
  import sd_emmc_ddr_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic din,
  input  logic shift,
  output logic dout
);

  logic [15:0] crc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[14:0], 1'b0} ^ ({16{crc[15] ^ din}} & CRC16_POLY);
    end else if (shift) begin
      crc <= {crc[14:0], 1'b0};
    end
  end

  assign dout = crc[15];

endmodule

// File: rtl/sd_emmc_ddr_tx_seq.sv
// 8-bit DDR eMMC write-block sequencer feeding the per-bit ODDR stage.
// Define SD_EMMC_DDR_TX_CRC_EN to build the per-line CRC16 phase; without it DATA goes straight to END.
module sd_emmc_ddr_tx_seq
  import sd_emmc_ddr_pkg::*;
#(
  parameter int BLK_LEN_W = 12,
  parameter int BLK_CNT_W = 16,
  parameter int GAP_CYC   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [BLK_LEN_W-1:0] blk_len,
  input  logic [BLK_CNT_W-1:0] blk_cnt,
  input  logic [31:0]          fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_rd,
  output logic [7:0]           d1_out,
  output logic [7:0]           d2_out,
  output logic                 dat_oe,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun,
  output logic [2:0]           fsm_state
);

`ifdef SD_EMMC_DDR_TX_CRC_EN
  localparam state_t AFTER_DATA = ST_CRC;
`else
  localparam state_t AFTER_DATA = ST_END;
`endif

  state_t               state, state_nx;
  logic [BLK_LEN_W-1:0] cnt, len_q;
  logic [BLK_CNT_W-1:0] blk_left;
  logic                 underrun_q, done_q;
  logic                 h, last_pair, accept, starve;
  logic [7:0]           rise_byte, fall_byte, crc_rise, crc_fall;

  // cnt is the byte count inside DATA, so bit 1 is the half-word select.
  assign h         = cnt[1];
  assign last_pair = (cnt + BLK_LEN_W'(2)) == len_q;
  assign accept    = (state == ST_IDLE) && start && !abort;
  assign starve    = (state == ST_DATA) && !h && fifo_empty;
  assign rise_byte = h ? fifo_data[15:8] : fifo_data[31:24];
  assign fall_byte = h ? fifo_data[7:0]  : fifo_data[23:16];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nx = ST_WAIT;
        ST_WAIT:  if (!fifo_empty) state_nx = ST_START;
        ST_START: state_nx = ST_DATA;
        ST_DATA: begin
          if (starve)                state_nx = ST_IDLE;
          else if (h && last_pair)   state_nx = AFTER_DATA;
        end
        ST_CRC:   if (cnt == BLK_LEN_W'(CRC_LEN - 1)) state_nx = ST_END;
        ST_END:   state_nx = (blk_left == BLK_CNT_W'(1)) ? ST_IDLE : ST_GAP;
        ST_GAP:   if (cnt == BLK_LEN_W'(GAP_CYC - 1)) state_nx = ST_WAIT;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    d1_out  = IDLE_BYTE;
    d2_out  = IDLE_BYTE;
    dat_oe  = 1'b0;
    fifo_rd = 1'b0;
    case (state)
      ST_WAIT, ST_END, ST_GAP: dat_oe = 1'b1;
      ST_START: begin
        d1_out = START_BYTE;
        d2_out = START_BYTE;
        dat_oe = 1'b1;
      end
      ST_DATA: begin
        if (!starve) begin
          d1_out  = rise_byte;
          d2_out  = fall_byte;
          dat_oe  = 1'b1;
          fifo_rd = h && !fifo_empty;
        end
      end
      ST_CRC: begin
        d1_out = crc_rise;
        d2_out = crc_fall;
        dat_oe = 1'b1;
      end
      default: ;
    endcase
  end

  // Shared phase counter: bytes in DATA, cycles in CRC and GAP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_nx != state) begin
      cnt <= '0;
    end else if (state == ST_DATA) begin
      cnt <= cnt + BLK_LEN_W'(2);
    end else if (state == ST_CRC || state == ST_GAP) begin
      cnt <= cnt + BLK_LEN_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q      <= '0;
      blk_left   <= '0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        len_q      <= blk_len;
        blk_left   <= blk_cnt;
        underrun_q <= 1'b0;
      end
      if (!abort) begin
        if (starve) underrun_q <= 1'b1;
        if (state == ST_END) begin
          blk_left <= blk_left - BLK_CNT_W'(1);
          done_q   <= (blk_left == BLK_CNT_W'(1));
        end
      end
    end
  end

`ifdef SD_EMMC_DDR_TX_CRC_EN
  logic crc_clear, crc_en, crc_shift;

  assign crc_clear = (state == ST_START);
  assign crc_en    = (state == ST_DATA) && !starve;
  assign crc_shift = (state == ST_CRC);

  for (genvar i = 0; i < 8; i++) begin : g_line
    sd_emmc_crc16_ser u_crc_rise (
      .clock  (clock),
      .reset  (reset),
      .clear  (crc_clear),
      .enable (crc_en),
      .din    (rise_byte[i]),
      .shift  (crc_shift),
      .dout   (crc_rise[i])
    );
    sd_emmc_crc16_ser u_crc_fall (
      .clock  (clock),
      .reset  (reset),
      .clear  (crc_clear),
      .enable (crc_en),
      .din    (fall_byte[i]),
      .shift  (crc_shift),
      .dout   (crc_fall[i])
    );
  end
`else
  assign crc_rise = IDLE_BYTE;
  assign crc_fall = IDLE_BYTE;
`endif

  assign busy      = (state != ST_IDLE);
  assign done      = done_q;
  assign underrun  = underrun_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_sd_emmc_ddr_tx_seq.sv
// Bench for sd_emmc_ddr_tx_seq: per-cycle frame model with a FWFT FIFO model;
// handles builds with or without SD_EMMC_DDR_TX_CRC_EN.
module tb_sd_emmc_ddr_tx_seq;

  localparam int BLK_LEN_W = 12;
  localparam int BLK_CNT_W = 16;
  localparam int GAP_CYC   = 2;

  logic                 clock = 1'b0;
  logic                 reset, start, abort;
  logic [BLK_LEN_W-1:0] blk_len;
  logic [BLK_CNT_W-1:0] blk_cnt;
  logic [31:0]          fifo_data;
  logic                 fifo_empty;
  logic                 fifo_rd;
  logic [7:0]           d1_out, d2_out;
  logic                 dat_oe, busy, done, underrun;
  logic [2:0]           fsm_state;

  int n_vec    = 0;
  int n_err    = 0;
  int rd_count = 0;

  logic [31:0] fq[$];
  logic [31:0] words[$];
  // {busy, done, dat_oe, d1, d2}
  logic [18:0] exp_q[$];

  always #5 clock = ~clock;

  sd_emmc_ddr_tx_seq #(
    .BLK_LEN_W (BLK_LEN_W),
    .BLK_CNT_W (BLK_CNT_W),
    .GAP_CYC   (GAP_CYC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .blk_len    (blk_len),
    .blk_cnt    (blk_cnt),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .d1_out     (d1_out),
    .d2_out     (d2_out),
    .dat_oe     (dat_oe),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun),
    .fsm_state  (fsm_state)
  );

  function automatic logic [18:0] mk(input logic bz, input logic dn, input logic oe,
                                     input logic [7:0] a, input logic [7:0] b);
    return {bz, dn, oe, a, b};
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  function automatic void fifo_refresh();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() > 0) ? fq[0] : 32'hA5A5A5A5;
  endfunction

  // Called at a falling edge: lets one rising edge pass, applies any pop, returns at the next falling edge.
  task automatic step();
    logic rd;
    rd = fifo_rd;
    @(posedge clock);
    #1;
    if (rd && fq.size() > 0) void'(fq.pop_front());
    fifo_refresh();
    @(negedge clock);
  endtask

  task automatic do_start(input int len, input int cnt);
    blk_len = BLK_LEN_W'(len);
    blk_cnt = BLK_CNT_W'(cnt);
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  // Expected per-cycle frame, from WAIT through the idle cycle after the done pulse.
  task automatic build_transfer(input int len, input int cnt);
    int          w;
    logic [31:0] wd;
    logic [7:0]  rb, fb;
    logic [15:0] cr [8];
    logic [15:0] cf [8];
    w = 0;
    exp_q.delete();
    for (int b = 0; b < cnt; b++) begin
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 8'h00, 8'h00));
      for (int i = 0; i < 8; i++) begin
        cr[i] = 16'h0000;
        cf[i] = 16'h0000;
      end
      for (int k = 0; k < len / 4; k++) begin
        wd = words[w];
        w++;
        fq.push_back(wd);
        for (int hh = 0; hh < 2; hh++) begin
          rb = (hh == 0) ? wd[31:24] : wd[15:8];
          fb = (hh == 0) ? wd[23:16] : wd[7:0];
          exp_q.push_back(mk(1'b1, 1'b0, 1'b1, rb, fb));
          for (int i = 0; i < 8; i++) begin
            cr[i] = crc_step(cr[i], rb[i]);
            cf[i] = crc_step(cf[i], fb[i]);
          end
        end
      end
`ifdef SD_EMMC_DDR_TX_CRC_EN
      for (int j = 15; j >= 0; j--) begin
        for (int i = 0; i < 8; i++) begin
          rb[i] = cr[i][j];
          fb[i] = cf[i][j];
        end
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, rb, fb));
      end
`endif
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF));
      if (b < cnt - 1) begin
        for (int g = 0; g < GAP_CYC; g++) exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF));
      end
    end
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF));
    fifo_refresh();
  endtask

  // Compares n queued cycles (all when n < 0); the first is checked without advancing.
  task automatic run_expected(input int n, input string name);
    int          idx;
    logic [18:0] e, obs;
    idx = 0;
    while (exp_q.size() > 0 && (n < 0 || idx < n)) begin
      if (idx > 0) step();
      e   = exp_q.pop_front();
      obs = {busy, done, dat_oe, d1_out, d2_out};
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL %s cycle %0d: got {busy,done,oe,d1,d2}=%h want %h", name, idx, obs, e);
      end
      if (fifo_rd) begin
        rd_count++;
        n_vec++;
        if (fifo_empty) begin
          n_err++;
          $display("FAIL %s cycle %0d: fifo_rd while fifo_empty", name, idx);
        end
      end
      idx++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; blk_len = '0; blk_cnt = '0;
    fifo_refresh();
    step();
    n_vec++;
    if ({d1_out, d2_out} !== 16'hFFFF) begin
      n_err++; $display("FAIL reset_data: got %h want ffff", {d1_out, d2_out});
    end
    n_vec++;
    if ({fifo_rd, dat_oe, busy, done, underrun} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 00000", {fifo_rd, dat_oe, busy, done, underrun});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    words = '{32'h11223344, 32'h55667788};
    rd_count = 0;
    build_transfer(8, 1);
    do_start(8, 1);
    run_expected(-1, "single");
    n_vec++;
    if (rd_count != 2) begin
      n_err++; $display("FAIL single_rd_count: got %0d want 2", rd_count);
    end
  endtask

  task automatic test_zero_512();
    words.delete();
    for (int i = 0; i < 128; i++) words.push_back(32'h0);
    build_transfer(512, 1);
    do_start(512, 1);
    run_expected(-1, "zero512");
  endtask

  task automatic test_multi_block();
    words.delete();
    for (int i = 0; i < 6; i++) words.push_back($urandom);
    build_transfer(8, 3);
    do_start(8, 3);
    run_expected(-1, "multi3");
  endtask

  task automatic test_random();
    int len, cnt;
    for (int it = 0; it < 4; it++) begin
      len = 4 * $urandom_range(1, 16);
      cnt = $urandom_range(1, 3);
      words.delete();
      for (int i = 0; i < (len / 4) * cnt; i++) words.push_back($urandom);
      build_transfer(len, cnt);
      do_start(len, cnt);
      run_expected(-1, "random");
    end
  endtask

  task automatic test_underrun();
    fq.push_back(32'hCAFEF00D);
    fifo_refresh();
    exp_q.delete();
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 8'h00, 8'h00));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 8'hCA, 8'hFE));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 8'hF0, 8'h0D));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF));
    do_start(16, 1);
    run_expected(-1, "underrun");
    n_vec++;
    if (underrun !== 1'b1) begin
      n_err++; $display("FAIL underrun_set: got %b want 1", underrun);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (done !== 1'b0 || underrun !== 1'b1) begin
        n_err++; $display("FAIL underrun_hold: got done=%b underrun=%b want 0/1", done, underrun);
      end
    end
    words = '{32'h0BADBEEF, 32'h12345678};
    build_transfer(8, 1);
    do_start(8, 1);
    n_vec++;
    if (underrun !== 1'b0) begin
      n_err++; $display("FAIL underrun_clear: got %b want 0", underrun);
    end
    run_expected(-1, "after_underrun");
  endtask

  task automatic test_abort();
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back($urandom);
    build_transfer(16, 1);
    do_start(16, 1);
    run_expected(7, "abort_pre");
    abort = 1'b1;
    exp_q.delete();
    step();
    abort = 1'b0;
    n_vec++;
    if ({busy, done, dat_oe, d1_out, d2_out} !== mk(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF)) begin
      n_err++; $display("FAIL abort_idle: got %h want %h", {busy, done, dat_oe, d1_out, d2_out},
                        mk(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF));
    end
    fq.delete();
    fifo_refresh();
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (done !== 1'b0 || underrun !== 1'b0) begin
        n_err++; $display("FAIL abort_after: got done=%b underrun=%b want 0/0", done, underrun);
      end
    end
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL start_abort_idle: got busy=%b want 0", busy);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int mid;
`ifdef SD_EMMC_DDR_TX_CRC_EN
    mid = 9;
`else
    mid = 5;
`endif
    words = '{32'hDEAD0001, 32'hBEEF0002};
    build_transfer(8, 1);
    do_start(8, 1);
    run_expected(mid, "reset_pre");
    exp_q.delete();
    reset = 1'b1;
    #1;
    n_vec++;
    if ({dat_oe, busy, d1_out, d2_out} !== {1'b0, 1'b0, 16'hFFFF}) begin
      n_err++; $display("FAIL reset_mid_async: got oe=%b busy=%b d=%h want 0 0 ffff",
                        dat_oe, busy, {d1_out, d2_out});
    end
    fq.delete();
    fifo_refresh();
    step();
    reset = 1'b0;
    step();
    words = '{32'h11223344, 32'h55667788};
    build_transfer(8, 1);
    do_start(8, 1);
    run_expected(-1, "after_reset");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_zero_512();
    test_multi_block();
    test_random();
    test_underrun();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
